// File: rtl/fe_pkg.sv
// ---------------------------------------------------------------------------
// fe_pkg
// Shared constants for the field-multiplier arbiter:
//   FE_WIDTH   - operand/result width of the fe_mulx-class multiplier
//   ARB_RR     - round-robin arbitration mode
//   ARB_FIXED  - fixed-priority arbitration mode (lowest index wins)
//   tag_width  - bits needed to name one of n clients (at least 1)
// ---------------------------------------------------------------------------
package fe_pkg;

    localparam int FE_WIDTH  = 320;
    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    function automatic int tag_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fe_mul_arbiter_tag_fifo.sv
// ---------------------------------------------------------------------------
// tag_fifo
// In-order FIFO of client tags for outstanding multiplies.
//   axiclk  in   clock
//   resetn  in   synchronous active-low reset (clears pointers)
//   push    in   write din at tail
//   pop     in   advance head (dout is the head before the pop)
//   din     in   tag to store
//   dout    out  head tag, combinational read of the head entry
//   empty   out  no tags stored
//   full    out  DEPTH tags stored
// Pointers carry one extra wrap bit: equal pointers mean empty, equal
// addresses with differing wrap bits mean full.
// ---------------------------------------------------------------------------
module tag_fifo #(
    parameter int DEPTH = 8,
    parameter int DW    = 2
) (
    input  logic          axiclk,
    input  logic          resetn,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          empty,
    output logic          full
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr_reg;
    logic [AW:0]   rd_ptr_reg;
    logic          do_push;
    logic          do_pop;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    // A push into a full FIFO is legal when the head leaves in the same cycle;
    // the head is read before the edge, so it sees the old entry.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Head is needed in the cycle of mul_done to route the response.
    assign dout = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge axiclk) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge axiclk) begin
        if (!resetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

endmodule

// File: rtl/fe_mul_arbiter.sv
// ---------------------------------------------------------------------------
// fe_mul_arbiter
// Shares one field multiplier among NUM_CLIENTS requesters. Grants are made
// round-robin (ARB_MODE=ARB_RR) or by fixed priority (ARB_MODE=ARB_FIXED),
// operands are registered into an issue register, and results are routed
// back in issue order through a tag FIFO.
//   axiclk, resetn          clock, synchronous active-low reset
//   req_valid/req_ready     per-client handshake (req_ready one-hot or zero)
//   req_op_a/req_op_b       client i operands at [i*WIDTH +: WIDTH]
//   mul_valid/mul_ready     issue handshake toward the multiplier
//   mul_op_a/mul_op_b       registered operands
//   mul_done/mul_res        in-order result from the multiplier
//   rsp_valid/rsp_res       registered one-hot strobe and shared result
//   inflight                accepted-but-unanswered count
//   err_spurious            sticky: mul_done with nothing outstanding
// ---------------------------------------------------------------------------
module fe_mul_arbiter
    import fe_pkg::*;
#(
    parameter int NUM_CLIENTS  = 4,
    parameter int WIDTH        = FE_WIDTH,
    parameter int MAX_INFLIGHT = 8,
    parameter int ARB_MODE     = ARB_RR
) (
    input  logic                              axiclk,
    input  logic                              resetn,
    input  logic [NUM_CLIENTS-1:0]            req_valid,
    output logic [NUM_CLIENTS-1:0]            req_ready,
    input  logic [NUM_CLIENTS*WIDTH-1:0]      req_op_a,
    input  logic [NUM_CLIENTS*WIDTH-1:0]      req_op_b,
    output logic                              mul_valid,
    output logic [WIDTH-1:0]                  mul_op_a,
    output logic [WIDTH-1:0]                  mul_op_b,
    input  logic                              mul_ready,
    input  logic                              mul_done,
    input  logic [WIDTH-1:0]                  mul_res,
    output logic [NUM_CLIENTS-1:0]            rsp_valid,
    output logic [WIDTH-1:0]                  rsp_res,
    output logic [$clog2(MAX_INFLIGHT):0]     inflight,
    output logic                              err_spurious
);
    localparam int TAG_W = tag_width(NUM_CLIENTS);
    localparam int CNT_W = $clog2(MAX_INFLIGHT) + 1;

    logic [WIDTH-1:0]       op_a_arr [NUM_CLIENTS];
    logic [WIDTH-1:0]       op_b_arr [NUM_CLIENTS];
    logic [TAG_W-1:0]       last_grant_reg;
    logic [TAG_W-1:0]       grant_idx;
    logic                   grant_any;
    logic                   issue_free;
    logic                   limit_ok;
    logic                   accept;
    logic                   pop;
    logic [TAG_W-1:0]       fifo_dout;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   mul_valid_reg;
    logic [WIDTH-1:0]       mul_op_a_reg;
    logic [WIDTH-1:0]       mul_op_b_reg;
    logic [CNT_W-1:0]       inflight_reg;
    logic [NUM_CLIENTS-1:0] rsp_valid_reg;
    logic [WIDTH-1:0]       rsp_res_reg;
    logic                   err_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CLIENTS; gi++) begin : g_slice
            assign op_a_arr[gi] = req_op_a[gi*WIDTH +: WIDTH];
            assign op_b_arr[gi] = req_op_b[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Requester selection. Loops run from the lowest-priority candidate to
    // the highest so the last match written is the winner.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        if (ARB_MODE == ARB_FIXED) begin
            for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
                if (req_valid[i]) begin
                    grant_any = 1'b1;
                    grant_idx = TAG_W'(i);
                end
            end
        end else begin
            for (int k = NUM_CLIENTS; k >= 1; k--) begin
                if (req_valid[(int'(last_grant_reg) + k) % NUM_CLIENTS]) begin
                    grant_any = 1'b1;
                    grant_idx = TAG_W'((int'(last_grant_reg) + k) % NUM_CLIENTS);
                end
            end
        end
    end

    assign issue_free = !mul_valid_reg || mul_ready;
    // inflight never exceeds MAX_INFLIGHT, so a concurrent mul_done is what
    // makes room at the limit (the pop frees the slot the push takes).
    assign limit_ok   = (inflight_reg < CNT_W'(MAX_INFLIGHT)) || (mul_done && !fifo_empty);

    always_comb begin
        req_ready = '0;
        if (resetn && grant_any && issue_free && limit_ok) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign accept = |(req_valid & req_ready);
    assign pop    = mul_done && !fifo_empty;

    tag_fifo #(
        .DEPTH (MAX_INFLIGHT),
        .DW    (TAG_W)
    ) u_tag_fifo (
        .axiclk (axiclk),
        .resetn (resetn),
        .push   (accept),
        .pop    (pop),
        .din    (grant_idx),
        .dout   (fifo_dout),
        .empty  (fifo_empty),
        .full   (fifo_full)
    );

    always_ff @(posedge axiclk) begin
        if (!resetn) begin
            mul_valid_reg  <= 1'b0;
            mul_op_a_reg   <= '0;
            mul_op_b_reg   <= '0;
            last_grant_reg <= TAG_W'(NUM_CLIENTS - 1);
            inflight_reg   <= '0;
            rsp_valid_reg  <= '0;
            rsp_res_reg    <= '0;
            err_reg        <= 1'b0;
        end else begin
            if (accept) begin
                mul_valid_reg  <= 1'b1;
                mul_op_a_reg   <= op_a_arr[grant_idx];
                mul_op_b_reg   <= op_b_arr[grant_idx];
                last_grant_reg <= grant_idx;
            end else if (mul_ready) begin
                mul_valid_reg  <= 1'b0;
            end

            inflight_reg <= inflight_reg + CNT_W'(accept) - CNT_W'(pop);

            rsp_valid_reg <= '0;
            if (pop) begin
                rsp_valid_reg[fifo_dout] <= 1'b1;
                rsp_res_reg              <= mul_res;
            end

            if (mul_done && fifo_empty) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign mul_valid    = mul_valid_reg;
    assign mul_op_a     = mul_op_a_reg;
    assign mul_op_b     = mul_op_b_reg;
    assign rsp_valid    = rsp_valid_reg;
    assign rsp_res      = rsp_res_reg;
    assign inflight     = inflight_reg;
    assign err_spurious = err_reg;

endmodule

// File: tb/tb_fe_mul_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fe_mul_arbiter
// Directed bench for fe_mul_arbiter: a round-robin instance (dut) and a
// fixed-priority instance (dut_fp). The bench plays the multiplier itself.
// ---------------------------------------------------------------------------
module tb_fe_mul_arbiter;
    import fe_pkg::*;

    localparam int N  = 4;
    localparam int W  = 320;
    localparam int M  = 8;
    localparam int CW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           resetn;
    logic [N-1:0]   req_valid, req_ready;
    logic [N*W-1:0] req_op_a, req_op_b;
    logic           mul_valid, mul_ready, mul_done;
    logic [W-1:0]   mul_op_a, mul_op_b, mul_res;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_res;
    logic [CW-1:0]  inflight;
    logic           err_spurious;

    logic [N-1:0]   f_req_valid, f_req_ready;
    logic [N*W-1:0] f_req_op_a, f_req_op_b;
    logic           f_mul_valid, f_mul_ready, f_mul_done;
    logic [W-1:0]   f_mul_op_a, f_mul_op_b, f_mul_res;
    logic [N-1:0]   f_rsp_valid;
    logic [W-1:0]   f_rsp_res;
    logic [CW-1:0]  f_inflight;
    logic           f_err_spurious;

    int errors = 0;
    int checks = 0;

    fe_mul_arbiter #(.NUM_CLIENTS(N), .WIDTH(W), .MAX_INFLIGHT(M), .ARB_MODE(ARB_RR)) dut (
        .axiclk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op_a(req_op_a), .req_op_b(req_op_b),
        .mul_valid(mul_valid), .mul_op_a(mul_op_a), .mul_op_b(mul_op_b),
        .mul_ready(mul_ready), .mul_done(mul_done), .mul_res(mul_res),
        .rsp_valid(rsp_valid), .rsp_res(rsp_res),
        .inflight(inflight), .err_spurious(err_spurious)
    );

    fe_mul_arbiter #(.NUM_CLIENTS(N), .WIDTH(W), .MAX_INFLIGHT(M), .ARB_MODE(ARB_FIXED)) dut_fp (
        .axiclk(clk), .resetn(resetn),
        .req_valid(f_req_valid), .req_ready(f_req_ready),
        .req_op_a(f_req_op_a), .req_op_b(f_req_op_b),
        .mul_valid(f_mul_valid), .mul_op_a(f_mul_op_a), .mul_op_b(f_mul_op_b),
        .mul_ready(f_mul_ready), .mul_done(f_mul_done), .mul_res(f_mul_res),
        .rsp_valid(f_rsp_valid), .rsp_res(f_rsp_res),
        .inflight(f_inflight), .err_spurious(f_err_spurious)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_op_a[i*W +: W] = a;
        req_op_b[i*W +: W] = b;
    endtask

    initial begin
        resetn = 1'b0; req_valid = '0; req_op_a = '0; req_op_b = '0;
        mul_ready = 1'b1; mul_done = 1'b0; mul_res = '0;
        f_req_valid = '0; f_req_op_a = '0; f_req_op_b = '0;
        f_mul_ready = 1'b1; f_mul_done = 1'b0; f_mul_res = '0;
        step(); step();

        // Reset state
        check("rst_req_ready", req_ready, 0);
        check("rst_mul_valid", mul_valid, 0);
        check("rst_mul_op_a", mul_op_a, 0);
        check("rst_mul_op_b", mul_op_b, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_res", rsp_res, 0);
        check("rst_inflight", inflight, 0);
        check("rst_err", err_spurious, 0);
        resetn = 1'b1;
        step();

        // Round-robin: all clients request, grants 0,1,2,3,0
        for (int i = 0; i < N; i++) set_op(i, W'(i + 1), W'(10));
        req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            #1 check("rr_ready", req_ready, W'(1) << (k % N));
            step();
            check("rr_op_a", mul_op_a, W'((k % N) + 1));
            check("rr_mul_valid", mul_valid, 1);
        end
        req_valid = '0;
        check("rr_inflight5", inflight, 5);
        for (int k = 0; k < 5; k++) begin
            mul_done = 1'b1;
            mul_res  = W'(10 * ((k % N) + 1));
            step();
            check("rr_rsp_valid", rsp_valid, W'(1) << (k % N));
            check("rr_rsp_res", rsp_res, W'(10 * ((k % N) + 1)));
        end
        mul_done = 1'b0;
        step();
        check("rr_inflight_idle", inflight, 0);
        check("rr_rsp_idle", rsp_valid, 0);

        // Single client: client 1, 3*5 returned after 4 cycles
        set_op(1, W'(3), W'(5));
        req_valid = 4'b0010;
        #1 check("single_ready", req_ready, 4'b0010);
        step();
        req_valid = '0;
        check("single_mul_valid", mul_valid, 1);
        check("single_op_a", mul_op_a, 3);
        check("single_op_b", mul_op_b, 5);
        check("single_inflight1", inflight, 1);
        step(); step(); step();
        check("single_issued", mul_valid, 0);
        mul_done = 1'b1; mul_res = W'(15);
        step();
        mul_done = 1'b0;
        check("single_rsp_valid", rsp_valid, 4'b0010);
        check("single_rsp_res", rsp_res, 15);
        check("single_inflight0", inflight, 0);
        step();
        check("single_rsp_pulse", rsp_valid, 0);

        // Backpressure: mul_ready low for 5 cycles
        mul_ready = 1'b0;
        set_op(2, W'(7), W'(9));
        set_op(3, W'(11), W'(11));
        req_valid = 4'b0100;
        #1 check("bp_first_ready", req_ready, 4'b0100);
        step();
        req_valid = 4'b1000;
        for (int k = 0; k < 5; k++) begin
            #1 check("bp_hold_ready", req_ready, 0);
            check("bp_hold_op_a", mul_op_a, 7);
            check("bp_hold_valid", mul_valid, 1);
            step();
        end
        mul_ready = 1'b1;
        #1 check("bp_release_ready", req_ready, 4'b1000);
        step();
        req_valid = '0;
        check("bp_next_op_a", mul_op_a, 11);
        check("bp_inflight2", inflight, 2);
        mul_done = 1'b1; mul_res = W'(63);
        step();
        check("bp_rsp0_valid", rsp_valid, 4'b0100);
        check("bp_rsp0_res", rsp_res, 63);
        mul_res = W'(121);
        step();
        mul_done = 1'b0;
        check("bp_rsp1_valid", rsp_valid, 4'b1000);
        check("bp_rsp1_res", rsp_res, 121);
        check("bp_inflight0", inflight, 0);

        // Accept limit: fill to 8, then swap with mul_done
        set_op(0, W'(2), W'(2));
        req_valid = 4'b0001;
        for (int k = 0; k < M; k++) step();
        check("lim_inflight8", inflight, 8);
        #1 check("lim_full_ready", req_ready, 0);
        step();
        check("lim_hold_inflight", inflight, 8);
        check("lim_issue_drained", mul_valid, 0);
        mul_done = 1'b1; mul_res = W'(42);
        #1 check("lim_swap_ready", req_ready, 4'b0001);
        step();
        req_valid = '0;
        check("lim_swap_inflight", inflight, 8);
        check("lim_swap_mul_valid", mul_valid, 1);
        check("lim_swap_rsp_valid", rsp_valid, 4'b0001);
        check("lim_swap_rsp_res", rsp_res, 42);
        for (int k = 0; k < M; k++) step();
        mul_done = 1'b0;
        check("lim_drain_inflight", inflight, 0);
        check("lim_no_spurious", err_spurious, 0);
        step();

        // Spurious result
        mul_done = 1'b1; mul_res = W'(99);
        step();
        mul_done = 1'b0;
        check("sp_err", err_spurious, 1);
        check("sp_rsp_valid", rsp_valid, 0);
        check("sp_inflight", inflight, 0);
        step(); step();
        check("sp_err_sticky", err_spurious, 1);

        // Reset with 3 operations outstanding (grants 1,2,3)
        req_valid = 4'b1110;
        step(); step(); step();
        req_valid = '0;
        check("mr_inflight3", inflight, 3);
        check("mr_op_a", mul_op_a, 11);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        check("mr_mul_valid", mul_valid, 0);
        check("mr_op_a_clr", mul_op_a, 0);
        check("mr_op_b_clr", mul_op_b, 0);
        check("mr_inflight", inflight, 0);
        check("mr_err", err_spurious, 0);
        check("mr_rsp_valid", rsp_valid, 0);
        check("mr_rsp_res", rsp_res, 0);
        req_valid = '1;
        #1 check("mr_first_grant", req_ready, 4'b0001);
        step();
        req_valid = '0;
        check("mr_first_op_a", mul_op_a, 2);

        // Fixed priority: clients 0 and 2 both request
        f_req_op_a[0 +: W]   = W'(100);
        f_req_op_a[2*W +: W] = W'(200);
        f_req_valid = 4'b0101;
        #1 check("fp_ready_a", f_req_ready, 4'b0001);
        step();
        check("fp_op_a0", f_mul_op_a, 100);
        #1 check("fp_ready_b", f_req_ready, 4'b0001);
        step();
        f_req_valid = 4'b0100;
        #1 check("fp_ready_c", f_req_ready, 4'b0100);
        step();
        f_req_valid = '0;
        check("fp_op_a2", f_mul_op_a, 200);
        check("fp_inflight3", f_inflight, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fe_mul_arbiter.md
# fe_mul_arbiter

Parametrised arbiter sharing one field multiplier (fe_mulx-class, 320-bit operands) among NUM_CLIENTS requesters: ge_frombytes, double-scalarmult and future point-op engines in the EPU. Replaces ad-hoc per-module mux logic with registered valid/ready issue and selectable round-robin or fixed-priority arbitration. Results are routed back to the issuing client through an in-order tag FIFO, so several engines can run concurrently with up to MAX_INFLIGHT multiplies outstanding.

## Interface
- NUM_CLIENTS, 4: number of requesters, 2..8.
- WIDTH, 320: operand and result width, in bits.
- MAX_INFLIGHT, 8: maximum accepted-but-unanswered operations; power of 2, ≥2.
- ARB_MODE, 0: 0 = round-robin; 1 = fixed priority, lowest index wins.
- axiclk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low; clock axiclk.
- req_valid  in  NUM_CLIENTS  per-client request.
- req_ready  out  NUM_CLIENTS  per-client accept; one-hot or zero.
- req_op_a  in  NUM_CLIENTS*WIDTH  operand A; client i occupies slice [i*WIDTH +: WIDTH].
- req_op_b  in  NUM_CLIENTS*WIDTH  operand B; same slicing.
- mul_valid  out  1  operation presented to the multiplier.
- mul_op_a, mul_op_b  out  WIDTH  registered operands.
- mul_ready  in  1  multiplier accepts the presented operation.
- mul_done  in  1  one result, returned in issue order.
- mul_res  in  WIDTH  result, valid with mul_done.
- rsp_valid  out  NUM_CLIENTS  one-hot, one-cycle result strobe.
- rsp_res  out  WIDTH  registered result, shared by all clients.
- inflight  out  $clog2(MAX_INFLIGHT)+1  outstanding count.
- err_spurious  out  1  sticky: mul_done seen with no tag outstanding.

## Operation
- Issue register: holds mul_valid, mul_op_a and mul_op_b. It is free when mul_valid=0, or when mul_valid=1 and mul_ready=1 in the same cycle.
- Grant rule: a grant is made only when the issue register is free and the accept limit allows it (see below). The granted requester sees req_ready[g]=1 combinationally; all other req_ready bits are 0.
- ARB_MODE=0: search begins at last_grant+1 modulo NUM_CLIENTS. last_grant updates only on a completed handshake.
- ARB_MODE=1: the lowest-index asserted req_valid wins. last_grant is ignored.
- Handshake (req_valid[g] & req_ready[g]):
  - the selected operand slices load into the issue register;
  - mul_valid is set;
  - g is pushed into the tag FIFO;
  - inflight increments.
- Issue register holds steady while mul_valid=1 and mul_ready=0.
- Accept limit: inflight counts accepted-not-answered operations, including the one sitting in the issue register. A new accept is allowed when inflight < MAX_INFLIGHT, or when inflight = MAX_INFLIGHT and mul_done is asserted in the same cycle (pop and push together).
- Response on mul_done:
  - pop the tag FIFO head h;
  - next cycle, rsp_valid[h]=1 and rsp_res=mul_res;
  - inflight decrements.
  - Push and pop in the same cycle leave inflight unchanged.
- Spurious result (mul_done with FIFO empty): no rsp_valid is raised, err_spurious sets, and inflight stays 0. Only reset clears err_spurious.
- Reset values: req_ready=0, mul_valid=0, mul_op_a=mul_op_b=0, rsp_valid=0, rsp_res=0, inflight=0, err_spurious=0, last_grant=NUM_CLIENTS-1 (so client 0 is served first). Tag FIFO pointers clear.
- Reset mid-operation: the issue register and all tags are dropped. The multiplier shares resetn, so no stale results are expected.
- Clients must hold req_valid and operands stable until their ready; the arbiter does not check this.

## Timing
- Accept at cycle t gives mul_valid=1 at t+1.
- mul_done at cycle d gives rsp_valid at d+1.
- Arbiter overhead is 2 cycles total.
- Sustained throughput is one operation per cycle when mul_ready=1 and inflight < MAX_INFLIGHT.
- req_ready depends combinationally on req_valid, mul_ready and mul_done only. It has no path from operand inputs.
- rsp_valid and rsp_res are registered, with no combinational path from mul_res.

## Structure
- Package fe_pkg:
  - FE_WIDTH=320;
  - arbitration-mode constants ARB_RR=0 and ARB_FIXED=1;
  - $clog2-based tag-width helper.
- Sub-module tag_fifo: synchronous, depth MAX_INFLIGHT, width $clog2(NUM_CLIENTS). Ports: push, pop, din, dout, empty, full. Uses a single extra pointer bit for full/empty detection.
- Top level contains the grant logic, the issue register and the response register.

## Test plan
- Single client: client 1 requests A=3, B=5; multiplier returns 15 after 4 cycles. Expect mul_valid at t+1, rsp_valid=4'b0010 with rsp_res=15 at done+1, and inflight back to 0.
- Round-robin: all four clients hold req_valid with mul_ready=1. Expect grants 0,1,2,3,0 on consecutive cycles and responses routed in the same order.
- Fixed priority (ARB_MODE=1): clients 0 and 2 both hold requests. Client 2 is granted only after client 0 drops req_valid.
- Backpressure and limit:
  - Hold mul_ready=0 for 5 cycles: mul_op_a stays stable and req_ready=0.
  - Fill to MAX_INFLIGHT=8 with no done: req_ready=0.
  - Then assert mul_done together with a pending request: the accept happens that cycle and inflight stays 8.
- Spurious result: pulse mul_done with nothing outstanding. Expect err_spurious=1 sticky, no rsp_valid, inflight=0.
- Reset mid-operation: 3 operations outstanding, then drive resetn low for one cycle. Expect all outputs at reset values and the next grant to go to client 0.
